// File: rtl/image_mem_arbiter_if.sv
// Bundles the display, host and line-memory signals of image_mem_arbiter.
// slave is the arbiter's view; master is the requester/memory side.
`timescale 1ns/1ps
interface image_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 19
);
  logic              DISP_REQ;
  logic [ADDR_W-1:0] DISP_ADDR;
  logic [DATA_W-1:0] DISP_DATA;
  logic              DISP_VALID;
  logic              HOST_REQ;
  logic [ADDR_W-1:0] HOST_ADDR;
  logic [DATA_W-1:0] HOST_DATA;
  logic              HOST_ACK;
  logic              HOST_ERR;
  logic              MEM_EN;
  logic              MEM_WE;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [DATA_W-1:0] MEM_WDATA;
  logic [DATA_W-1:0] MEM_RDATA;

  modport slave (
    input  DISP_REQ, DISP_ADDR, HOST_REQ, HOST_ADDR, HOST_DATA, MEM_RDATA,
    output DISP_DATA, DISP_VALID, HOST_ACK, HOST_ERR,
           MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA
  );

  modport master (
    output DISP_REQ, DISP_ADDR, HOST_REQ, HOST_ADDR, HOST_DATA, MEM_RDATA,
    input  DISP_DATA, DISP_VALID, HOST_ACK, HOST_ERR,
           MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA
  );
endinterface

// File: rtl/image_mem_arbiter.sv
// Line-memory arbiter: display reads have priority, host writes win after STARVE_LIMIT losses.
// Optional macro IMG_VBLANK_WRITE_EN adds a VBLANK input restricting host grants to blanking.
`timescale 1ns/1ps
module image_mem_arbiter #(
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned DATA_W       = 19,
  parameter int unsigned LINES        = 10,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic CLK,
  input  logic RESET,
  input  logic CE,
`ifdef IMG_VBLANK_WRITE_EN
  input  logic VBLANK,
`endif
  image_mem_arbiter_if.slave bus
);

  localparam int unsigned    CNT_W      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_CAPT  = 3'd2,
    WR_ISSUE = 3'd3,
    WR_ACK   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              rd_oor_q, rd_oor_d;
  logic              host_mask_q, host_mask_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] disp_data_q, disp_data_d;
  logic              disp_valid_q, disp_valid_d;
  logic              host_ack_q, host_ack_d;
  logic              host_err_q, host_err_d;

  logic disp_oor_c, host_oor_c, host_window_c, host_pend_c;
  logic host_win_c, disp_win_c;

  assign disp_oor_c = 32'(bus.DISP_ADDR) >= LINES;
  assign host_oor_c = 32'(bus.HOST_ADDR) >= LINES;

`ifdef IMG_VBLANK_WRITE_EN
  assign host_window_c = VBLANK;
`else
  assign host_window_c = 1'b1;
`endif

  // Host is masked in the IDLE cycle right after its ACK so a held REQ is not served twice.
  assign host_pend_c = bus.HOST_REQ && !host_mask_q && host_window_c;

  // The IDLE cycle carrying DISP_VALID does not arbitrate, for the same reason on the display side.
  always_comb begin
    host_win_c = 1'b0;
    disp_win_c = 1'b0;
    if (state_q == IDLE && CE && !disp_valid_q) begin
      if (host_pend_c && starve_q >= STARVE_MAX) host_win_c = 1'b1;
      else if (bus.DISP_REQ)                     disp_win_c = 1'b1;
      else if (host_pend_c)                      host_win_c = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    starve_d     = starve_q;
    rd_oor_d     = rd_oor_q;
    host_mask_d  = (state_q == WR_ACK);
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    disp_data_d  = disp_data_q;
    disp_valid_d = 1'b0;
    host_ack_d   = 1'b0;
    host_err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (disp_win_c) begin
          state_d  = RD_ISSUE;
          rd_oor_d = disp_oor_c;
          mem_en_d = !disp_oor_c;
          if (!disp_oor_c) mem_addr_d = bus.DISP_ADDR;
          if (bus.HOST_REQ && starve_q < STARVE_MAX) starve_d = CNT_W'(starve_q + 1'b1);
        end else if (host_win_c) begin
          if (host_oor_c) begin
            state_d    = WR_ACK;
            host_ack_d = 1'b1;
            host_err_d = 1'b1;
            starve_d   = '0;
          end else begin
            state_d     = WR_ISSUE;
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = bus.HOST_ADDR;
            mem_wdata_d = bus.HOST_DATA;
          end
        end
      end
      RD_ISSUE: state_d = RD_CAPT;
      RD_CAPT: begin
        disp_data_d  = rd_oor_q ? '0 : bus.MEM_RDATA;
        disp_valid_d = 1'b1;
        state_d      = IDLE;
      end
      WR_ISSUE: begin
        host_ack_d = 1'b1;
        starve_d   = '0;
        state_d    = WR_ACK;
      end
      WR_ACK:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      starve_q     <= '0;
      rd_oor_q     <= 1'b0;
      host_mask_q  <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
      host_ack_q   <= 1'b0;
      host_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      rd_oor_q     <= rd_oor_d;
      host_mask_q  <= host_mask_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      disp_data_q  <= disp_data_d;
      disp_valid_q <= disp_valid_d;
      host_ack_q   <= host_ack_d;
      host_err_q   <= host_err_d;
    end
  end

  assign bus.MEM_EN     = mem_en_q;
  assign bus.MEM_WE     = mem_we_q;
  assign bus.MEM_ADDR   = mem_addr_q;
  assign bus.MEM_WDATA  = mem_wdata_q;
  assign bus.DISP_DATA  = disp_data_q;
  assign bus.DISP_VALID = disp_valid_q;
  assign bus.HOST_ACK   = host_ack_q;
  assign bus.HOST_ERR   = host_err_q;

endmodule

// File: tb/tb_image_mem_arbiter.sv
// Self-checking bench for image_mem_arbiter: vector table of single transactions
// plus hand-written sequences for starvation, mid-write reset and clock enable.
`timescale 1ns/1ps
module tb_image_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b0;

  always #5 clk = ~clk;

  image_mem_arbiter_if #(.ADDR_W(4), .DATA_W(19)) bus ();

  image_mem_arbiter #(
    .ADDR_W(4), .DATA_W(19), .LINES(10), .STARVE_LIMIT(8)
  ) dut (
    .CLK  (clk),
    .RESET(rst),
    .CE   (ce),
    .bus  (bus)
  );

  // Line memory model: one-cycle read latency, with a bench-side preload port.
  logic [18:0] mem [0:15];
  logic [18:0] rdata;
  logic        ld_en = 1'b0;
  logic [3:0]  ld_addr = '0;
  logic [18:0] ld_data = '0;

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (bus.MEM_EN && bus.MEM_WE) mem[bus.MEM_ADDR] <= bus.MEM_WDATA;
    if (bus.MEM_EN && !bus.MEM_WE) rdata <= mem[bus.MEM_ADDR];
  end
  assign bus.MEM_RDATA = rdata;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] a, input logic [18:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic do_txn(input logic is_host, input logic [3:0] addr, input logic [18:0] data,
                        output int lat, output logic [18:0] rd, output logic err,
                        output int en_cnt, output int en_cyc, output logic [3:0] en_addr,
                        output logic en_we, output logic [18:0] en_wdata);
    lat = -1; rd = '0; err = 1'b0; en_cnt = 0; en_cyc = -1;
    en_addr = '0; en_we = 1'b0; en_wdata = '0;
    ce = 1'b1;
    if (is_host) begin
      bus.HOST_REQ = 1'b1; bus.HOST_ADDR = addr; bus.HOST_DATA = data;
    end else begin
      bus.DISP_REQ = 1'b1; bus.DISP_ADDR = addr;
    end
    for (int n = 1; n <= 16 && lat < 0; n++) begin
      tick();
      if (bus.MEM_EN) begin
        en_cnt++; en_cyc = n;
        en_addr = bus.MEM_ADDR; en_we = bus.MEM_WE; en_wdata = bus.MEM_WDATA;
      end
      if (!is_host && bus.DISP_VALID) begin lat = n; rd = bus.DISP_DATA; end
      if (is_host && bus.HOST_ACK) begin lat = n; err = bus.HOST_ERR; end
    end
    bus.DISP_REQ = 1'b0;
    bus.HOST_REQ = 1'b0;
    tick();
    tick();
  endtask

  typedef struct {
    logic        is_host;
    logic [3:0]  addr;
    logic [18:0] data;
    int          exp_lat;
    logic [18:0] exp_rd;
    logic        exp_err;
    int          exp_en;
  } vec_t;

  vec_t vecs [10];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int          lat, en_cnt, en_cyc, ev, b2b, acks, wr, cnt_en, cnt_v;
    logic [18:0] rd, en_wdata;
    logic        err, en_we, prev_en;
    logic [3:0]  en_addr;

    vecs[0] = '{1'b0, 4'd3,  19'h00000, 3, 19'h5A5A5, 1'b0, 1};
    vecs[1] = '{1'b1, 4'd7,  19'h7FFFF, 2, 19'h00000, 1'b0, 1};
    vecs[2] = '{1'b0, 4'd7,  19'h00000, 3, 19'h7FFFF, 1'b0, 1};
    vecs[3] = '{1'b1, 4'd12, 19'h13579, 1, 19'h00000, 1'b1, 0};
    vecs[4] = '{1'b0, 4'd15, 19'h00000, 3, 19'h00000, 1'b0, 0};
    vecs[5] = '{1'b1, 4'd0,  19'h12345, 2, 19'h00000, 1'b0, 1};
    vecs[6] = '{1'b0, 4'd0,  19'h00000, 3, 19'h12345, 1'b0, 1};
    vecs[7] = '{1'b0, 4'd9,  19'h00000, 3, 19'h2C0DE, 1'b0, 1};
    vecs[8] = '{1'b1, 4'd10, 19'h55555, 1, 19'h00000, 1'b1, 0};
    vecs[9] = '{1'b0, 4'd10, 19'h00000, 3, 19'h00000, 1'b0, 0};

    bus.DISP_REQ = 1'b0; bus.DISP_ADDR = '0;
    bus.HOST_REQ = 1'b0; bus.HOST_ADDR = '0; bus.HOST_DATA = '0;

    // Preload while the arbiter is held in reset.
    for (int i = 0; i < 16; i++) begin
      case (i)
        3:       load(4'(i), 19'h5A5A5);
        9:       load(4'(i), 19'h2C0DE);
        10:      load(4'(i), 19'h11111);
        15:      load(4'(i), 19'h7EEEE);
        default: load(4'(i), 19'(32'h40000 + 32'(i) * 32'h111));
      endcase
    end

    chk("reset_mem_ctrl", {30'd0, bus.MEM_EN, bus.MEM_WE}, 32'd0);
    chk("reset_mem_addr", 32'(bus.MEM_ADDR), 32'd0);
    chk("reset_mem_wdata", 32'(bus.MEM_WDATA), 32'd0);
    chk("reset_disp", {12'd0, bus.DISP_VALID, bus.DISP_DATA}, 32'd0);
    chk("reset_host", {30'd0, bus.HOST_ACK, bus.HOST_ERR}, 32'd0);
    #2 rst = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      do_txn(vecs[i].is_host, vecs[i].addr, vecs[i].data,
             lat, rd, err, en_cnt, en_cyc, en_addr, en_we, en_wdata);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("vec%0d_mem_en_count", i), 32'(en_cnt), 32'(vecs[i].exp_en));
      if (vecs[i].is_host) chk($sformatf("vec%0d_host_err", i), 32'(err), 32'(vecs[i].exp_err));
      else                 chk($sformatf("vec%0d_disp_data", i), 32'(rd), 32'(vecs[i].exp_rd));
      if (vecs[i].exp_en == 1) begin
        chk($sformatf("vec%0d_mem_en_cycle", i), 32'(en_cyc), 32'd1);
        chk($sformatf("vec%0d_mem_addr", i), 32'(en_addr), 32'(vecs[i].addr));
        chk($sformatf("vec%0d_mem_we", i), 32'(en_we), 32'(vecs[i].is_host));
        if (vecs[i].is_host) chk($sformatf("vec%0d_mem_wdata", i), 32'(en_wdata), 32'(vecs[i].data));
      end
    end

    // Reset asserted while the write strobe is on the bus.
    ce = 1'b1;
    bus.HOST_REQ = 1'b1; bus.HOST_ADDR = 4'd5; bus.HOST_DATA = 19'h3C3C3;
    tick();
    chk("rst_pre_write_strobe", {30'd0, bus.MEM_EN, bus.MEM_WE}, 32'd3);
    #2 rst = 1'b1;
    #1 chk("rst_async_mem_en", 32'(bus.MEM_EN), 32'd0);
    tick();
    chk("rst_no_ack", 32'(bus.HOST_ACK), 32'd0);
    rst = 1'b0;
    acks = 0; wr = 0;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (bus.MEM_EN && bus.MEM_WE) wr++;
      if (bus.HOST_ACK) begin acks++; bus.HOST_REQ = 1'b0; end
    end
    bus.HOST_REQ = 1'b0;
    chk("rst_reissue_writes", 32'(wr), 32'd1);
    chk("rst_reissue_acks", 32'(acks), 32'd1);
    do_txn(1'b0, 4'd5, 19'h0, lat, rd, err, en_cnt, en_cyc, en_addr, en_we, en_wdata);
    chk("rst_readback_line5", 32'(rd), 32'h3C3C3);

    // Both requesters held high: eight display grants, then one host grant, repeating.
    bus.DISP_REQ = 1'b1; bus.DISP_ADDR = 4'd1;
    bus.HOST_REQ = 1'b1; bus.HOST_ADDR = 4'd2; bus.HOST_DATA = 19'h0ABCD;
    ev = 0; b2b = 0; prev_en = 1'b0;
    for (int n = 0; n < 300 && ev < 18; n++) begin
      tick();
      if (bus.MEM_EN) begin
        if (prev_en) b2b++;
        chk($sformatf("starve_grant%0d_is_host", ev), 32'(bus.MEM_WE), ((ev % 9) == 8) ? 32'd1 : 32'd0);
        ev++;
      end
      prev_en = bus.MEM_EN;
    end
    chk("starve_grant_count", 32'(ev), 32'd18);
    chk("starve_no_back_to_back", 32'(b2b), 32'd0);
    bus.DISP_REQ = 1'b0; bus.HOST_REQ = 1'b0;
    repeat (6) tick();

    // CE low blocks acceptance; CE dropping mid-read does not stall it.
    ce = 1'b0;
    bus.DISP_REQ = 1'b1; bus.DISP_ADDR = 4'd3;
    cnt_en = 0; cnt_v = 0;
    repeat (5) begin
      tick();
      if (bus.MEM_EN) cnt_en++;
      if (bus.DISP_VALID) cnt_v++;
    end
    chk("ce0_no_mem_en", 32'(cnt_en), 32'd0);
    chk("ce0_no_valid", 32'(cnt_v), 32'd0);
    ce = 1'b1;
    lat = -1; rd = '0;
    for (int n = 1; n <= 10 && lat < 0; n++) begin
      tick();
      ce = 1'b0;
      if (bus.DISP_VALID) begin lat = n; rd = bus.DISP_DATA; end
    end
    bus.DISP_REQ = 1'b0;
    chk("ce_mid_read_latency", 32'(lat), 32'd3);
    chk("ce_mid_read_data", 32'(rd), 32'h5A5A5);
    tick();
    chk("ce_mid_read_single_pulse", 32'(bus.DISP_VALID), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
